// File: rtl/noc_params.sv
// Shared NoC parameters and types: mesh geometry, VC count, flit layout,
// and the local injector FSM state encoding.
package noc_params;

    localparam int MESH_SIZE_X      = 3;
    localparam int MESH_SIZE_Y      = 3;
    localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
    localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);
    localparam int VC_NUM           = 4;
    localparam int VC_SIZE          = $clog2(VC_NUM);
    localparam int FLIT_DATA_SIZE   = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t               flit_label;
        logic [VC_SIZE-1:0]        vc_id;
        logic [FLIT_DATA_SIZE-1:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        INJ_IDLE  = 2'd0,
        INJ_ALLOC = 2'd1,
        INJ_SEND  = 2'd2
    } inj_state_t;

    // Head payload, low bits upward: dst_y, dst_x, src_y, src_x; zero above.
    function automatic logic [FLIT_DATA_SIZE-1:0] head_payload(
        input logic [DEST_ADDR_SIZE_X-1:0] src_x,
        input logic [DEST_ADDR_SIZE_Y-1:0] src_y,
        input logic [DEST_ADDR_SIZE_X-1:0] dst_x,
        input logic [DEST_ADDR_SIZE_Y-1:0] dst_y
    );
        return FLIT_DATA_SIZE'({src_x, src_y, dst_x, dst_y});
    endfunction

endpackage

// File: rtl/router2router.sv
// Router-to-router link: flit plus valid downstream, per-VC on/off credit
// and allocatable flags upstream.
interface router2router;
    import noc_params::*;

    flit_t               data;
    logic                is_valid;
    logic [VC_NUM-1:0]   is_on_off;
    logic [VC_NUM-1:0]   is_allocatable;

    modport upstream (
        output data,
        output is_valid,
        input  is_on_off,
        input  is_allocatable
    );

    modport downstream (
        input  data,
        input  is_valid,
        output is_on_off,
        output is_allocatable
    );
endinterface

// File: rtl/inj_vc_select.sv
// Fixed-priority downstream VC picker: lowest-index VC that is allocatable
// and not already claimed by a recently issued head.
module inj_vc_select
    import noc_params::*;
(
    input  logic [VC_NUM-1:0]  i_allocatable,
    input  logic [VC_NUM-1:0]  i_pending,
    output logic               o_valid,
    output logic [VC_SIZE-1:0] o_vc
);

    logic [VC_NUM-1:0] w_eligible;

    assign w_eligible = i_allocatable & ~i_pending;
    assign o_valid    = |w_eligible;

    // Scan high to low so the lowest eligible index is the last one written.
    always_comb begin
        o_vc = '0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (w_eligible[v]) begin
                o_vc = VC_SIZE'(v);
            end
        end
    end

endmodule

// File: rtl/local_injector.sv
// Packet-source endpoint driving a router LOCAL port: request -> VC pick -> flits.
// Define LOCAL_INJECTOR_STATS_EN to build the flit/packet/stall counters.
module local_injector
    import noc_params::*;
#(
    parameter int X_CURRENT = MESH_SIZE_X / 2,
    parameter int Y_CURRENT = MESH_SIZE_Y / 2,
    parameter int LEN_W     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    router2router.upstream              router_if_up,
    input  logic                        pkt_valid_i,
    output logic                        pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] pkt_dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] pkt_dest_y_i,
    input  logic [LEN_W-1:0]            pkt_len_i,
    input  logic [7:0]                  pkt_id_i,
    output logic                        dest_err_o,
    output logic [CNT_W-1:0]            flits_sent_o,
    output logic [CNT_W-1:0]            pkts_sent_o,
    output logic [CNT_W-1:0]            stall_cycles_o,
    output inj_state_t                  dbg_state_o
);

    localparam logic [DEST_ADDR_SIZE_X-1:0] SRC_X = DEST_ADDR_SIZE_X'(X_CURRENT);
    localparam logic [DEST_ADDR_SIZE_Y-1:0] SRC_Y = DEST_ADDR_SIZE_Y'(Y_CURRENT);

    inj_state_t                  r_state;
    inj_state_t                  w_next_state;
    logic                        r_rst_done;
    logic                        r_dest_err;
    logic [DEST_ADDR_SIZE_X-1:0] r_dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0] r_dest_y;
    logic [LEN_W-1:0]            r_len;
    logic [7:0]                  r_id;
    logic [LEN_W-1:0]            r_k;
    logic [VC_SIZE-1:0]          r_cur_vc;
    logic [VC_NUM-1:0]           r_pending;
    flit_t                       r_flit;
    logic                        r_valid;

    logic                        w_accept;
    logic                        w_dest_bad;
    logic [LEN_W-1:0]            w_len_fix;
    logic                        w_sel_valid;
    logic [VC_SIZE-1:0]          w_sel_vc;
    logic                        w_on_off;
    logic                        w_issue;
    logic                        w_last;
    logic [VC_NUM-1:0]           w_head_mask;
    flit_t                       w_flit;

    inj_vc_select u_vc_select (
        .i_allocatable (router_if_up.is_allocatable),
        .i_pending     (r_pending),
        .o_valid       (w_sel_valid),
        .o_vc          (w_sel_vc)
    );

    // Ready is held low for the first edge after reset release.
    assign pkt_ready_o = (r_state == INJ_IDLE) && r_rst_done;
    assign w_accept    = pkt_valid_i && pkt_ready_o;
    assign w_dest_bad  = ({1'b0, pkt_dest_x_i} >= (DEST_ADDR_SIZE_X + 1)'(MESH_SIZE_X)) ||
                         ({1'b0, pkt_dest_y_i} >= (DEST_ADDR_SIZE_Y + 1)'(MESH_SIZE_Y));
    assign w_len_fix   = (pkt_len_i == '0) ? LEN_W'(1) : pkt_len_i;
    assign w_on_off    = router_if_up.is_on_off[r_cur_vc];
    assign w_last      = (r_k == r_len - LEN_W'(1));
    assign w_head_mask = (w_issue && (r_k == '0)) ? (VC_NUM'(1) << r_cur_vc) : '0;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            INJ_IDLE: begin
                if (w_accept && !w_dest_bad) begin
                    w_next_state = INJ_ALLOC;
                end
            end
            INJ_ALLOC: begin
                if (w_sel_valid) begin
                    w_next_state = INJ_SEND;
                end
            end
            INJ_SEND: begin
                if (w_on_off) begin
                    w_issue = 1'b1;
                    if (w_last) begin
                        w_next_state = INJ_IDLE;
                    end
                end
            end
            default: w_next_state = INJ_IDLE;
        endcase
    end

    always_comb begin
        w_flit         = '0;
        w_flit.vc_id   = r_cur_vc;
        w_flit.payload = FLIT_DATA_SIZE'({r_id, r_k});
        if (r_len == LEN_W'(1)) begin
            w_flit.flit_label = HEADTAIL;
        end else if (r_k == '0) begin
            w_flit.flit_label = HEAD;
        end else if (w_last) begin
            w_flit.flit_label = TAIL;
        end else begin
            w_flit.flit_label = BODY;
        end
        if ((w_flit.flit_label == HEAD) || (w_flit.flit_label == HEADTAIL)) begin
            w_flit.payload = head_payload(SRC_X, SRC_Y, r_dest_x, r_dest_y);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= INJ_IDLE;
            r_rst_done <= 1'b0;
            r_dest_err <= 1'b0;
            r_dest_x   <= '0;
            r_dest_y   <= '0;
            r_len      <= '0;
            r_id       <= '0;
            r_k        <= '0;
            r_cur_vc   <= '0;
            r_pending  <= '0;
            r_flit     <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rst_done <= 1'b1;
            r_dest_err <= w_accept && w_dest_bad;
            if (w_accept && !w_dest_bad) begin
                r_dest_x <= pkt_dest_x_i;
                r_dest_y <= pkt_dest_y_i;
                r_len    <= w_len_fix;
                r_id     <= pkt_id_i;
            end
            if ((r_state == INJ_ALLOC) && w_sel_valid) begin
                r_cur_vc <= w_sel_vc;
                r_k      <= '0;
            end else if (w_issue) begin
                r_k <= r_k + LEN_W'(1);
            end
            // A VC stays claimed until the router drops its allocatable flag.
            r_pending <= (r_pending & router_if_up.is_allocatable) | w_head_mask;
            r_valid   <= w_issue;
            if (w_issue) begin
                r_flit <= w_flit;
            end
        end
    end

    assign router_if_up.data     = r_flit;
    assign router_if_up.is_valid = r_valid;
    assign dest_err_o            = r_dest_err;
    assign dbg_state_o           = r_state;

`ifdef LOCAL_INJECTOR_STATS_EN
    logic [CNT_W-1:0] r_flits_sent;
    logic [CNT_W-1:0] r_pkts_sent;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_stall;

    assign w_stall = ((r_state == INJ_ALLOC) && !w_sel_valid) ||
                     ((r_state == INJ_SEND) && !w_on_off);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flits_sent   <= '0;
            r_pkts_sent    <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_issue) begin
                r_flits_sent <= r_flits_sent + CNT_W'(1);
            end
            if (w_issue && w_last) begin
                r_pkts_sent <= r_pkts_sent + CNT_W'(1);
            end
            if (w_stall) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
        end
    end

    assign flits_sent_o   = r_flits_sent;
    assign pkts_sent_o    = r_pkts_sent;
    assign stall_cycles_o = r_stall_cycles;
`else
    assign flits_sent_o   = '0;
    assign pkts_sent_o    = '0;
    assign stall_cycles_o = '0;
`endif

endmodule

// File: doc/local_injector.md
# local_injector

Packet-source endpoint that drives a router's LOCAL input port as the sending side of the router2router link. It turns packet requests into HEAD/BODY/TAIL (or HEADTAIL) flits. It picks a free downstream VC using the router's per-VC allocatable flags, and it paces flits with the router's per-VC on/off credits. It sits in each mesh node in place of the processing element's network interface, and is also used as the traffic generator in mesh testbenches.

## Interface
- X_CURRENT, MESH_SIZE_X/2, source node X coordinate
- Y_CURRENT, MESH_SIZE_Y/2, source node Y coordinate
- LEN_W, 4, packet length field width in flits; max length 2^LEN_W-1
- CNT_W, 16, statistics counter width
- clk  input  1  single clock
- rst  input  1  asynchronous, active-high reset
- router_if_up  modport  router2router.upstream  carries the following signals:
  - data: output flit_t.
  - is_valid: output 1.
  - is_on_off: input [VC_NUM-1:0].
  - is_allocatable: input [VC_NUM-1:0].
- pkt_valid_i  input  1  packet request present
- pkt_ready_o  output  1  injector can accept a request
- pkt_dest_x_i  input  DEST_ADDR_SIZE_X  destination X
- pkt_dest_y_i  input  DEST_ADDR_SIZE_Y  destination Y
- pkt_len_i  input  LEN_W  flits in the packet; a value of 0 is treated as 1
- pkt_id_i  input  8  tag copied into every flit payload
- dest_err_o  output  1  one-cycle pulse when a request is dropped for an out-of-mesh destination
- flits_sent_o, pkts_sent_o, stall_cycles_o  output  CNT_W each  statistics counters

## Operation
The injector runs a three-state FSM: IDLE, ALLOC, SEND.

- **IDLE**
  - pkt_ready_o=1.
  - On pkt_valid_i&pkt_ready_o, latch the request fields.
  - If pkt_dest_x_i>=MESH_SIZE_X or pkt_dest_y_i>=MESH_SIZE_Y: pulse dest_err_o, stay in IDLE.
  - Otherwise go to ALLOC.
- **ALLOC**
  - A VC is eligible when is_allocatable[v]&~pending[v].
  - Choose the lowest-index eligible VC, latch it as cur_vc, go to SEND.
  - If no VC is eligible, wait in ALLOC and count stall cycles.
- **SEND**
  - In any cycle where is_on_off[cur_vc]=1, issue flit number k (k=0..len-1) and increment k.
  - Flit labels:
    - len=1: HEADTAIL.
    - k=0: HEAD.
    - k=len-1: TAIL.
    - Otherwise: BODY.
  - HEAD/HEADTAIL flits carry x_dest/y_dest. BODY/TAIL payloads are {pkt_id, k}. vc_id=cur_vc on every flit.
  - After issuing TAIL/HEADTAIL, go to IDLE.
  - If is_on_off[cur_vc]=0, issue nothing and increment stall_cycles_o.
- **pending[v]**
  - Set in the cycle HEAD/HEADTAIL is issued on v.
  - Cleared in the first later cycle with is_allocatable[v]=0, i.e. once the router has claimed the VC.
  - This stops a stale high allocatable flag from being reused before the router's flag updates.
  - If set and clear happen in the same cycle, set wins.
- At most one packet is in flight; pkt_ready_o=0 in ALLOC and SEND.
- Counters:
  - flits_sent_o increments once per issued flit.
  - pkts_sent_o increments once per TAIL/HEADTAIL.
  - All counters wrap modulo 2^CNT_W.

## Timing
- data and is_valid are registered. A flit decided in cycle t, using is_on_off sampled in cycle t, appears on the link in cycle t+1 with is_valid=1 for exactly one cycle.
- Minimum latency: request accepted in cycle 0 → ALLOC in cycle 1 → HEAD valid on the link in cycle 3 (decided in cycle 2).
- In SEND, back-to-back flits are issued at 1 per cycle while on/off stays high. A gap appears only in cycles where on/off is low.
- Reset values:
  - is_valid=0, data=0, pkt_ready_o=0 while rst is high, 1 after reset.
  - dest_err_o=0, all counters=0, pending=0, FSM=IDLE.
- Reset asserted mid-packet drops the rest of the packet immediately and clears is_valid asynchronously. Recovery of the router side is done by resetting the router as well.
- A request presented in the cycle reset is released is not accepted.

## Configuration
- LOCAL_INJECTOR_STATS_EN
  - Defined: flits_sent_o, pkts_sent_o and stall_cycles_o are implemented.
  - Undefined: no counter flops are built, and the three outputs are tied to 0. The ports stay in place either way.

## Structure
- flit_t, flit_label_t (HEAD, BODY, TAIL, HEADTAIL), VC_NUM, MESH_SIZE_X/Y and DEST_ADDR_SIZE_X/Y come from noc_params.
- The injector FSM state enum is added to noc_params.
- One sub-module, inj_vc_select: a combinational fixed-priority picker over is_allocatable&~pending that outputs a valid bit and a VC index.

## Test plan
- len=1, dest (1,2), all VCs allocatable, on/off high → one HEADTAIL on vc 0 in cycle 3; pkts_sent_o=1.
- len=4, on/off[0] held low for cycles 4-5 → HEAD, BODY, then a 2-cycle gap, then BODY, TAIL; stall_cycles_o=2.
- is_allocatable=0 on VC 0, 1 on VC 1 → packet uses vc_id=1.
- Back-to-back packets with allocatable still high on VC 0 → second packet takes VC 1 because pending[0] is set. Drop allocatable[0] and a third packet waits or takes another eligible VC.
- dest_x=MESH_SIZE_X → dest_err_o pulses once, no flit is sent, FSM stays in IDLE.
- Assert rst during the BODY flit of a len=5 packet → is_valid goes low immediately; after release, counters=0 and pkt_ready_o=1.
